hiscore_ram_arbiter: RTL and testbench

//  Shares one port of game work RAM between the CPU and the hiscore save/restore engine.
//  On hiscore request: halts the CPU, waits for ack plus a settle window, then hands the RAM port to the engine.

---
 rtl/hiscore_ram_arbiter_pkg.sv | 21 ++
 rtl/hiscore_ram_arbiter_if.sv | 42 ++++
 rtl/hiscore_ram_arbiter.sv | 128 ++++++++++++
 tb/tb_hiscore_ram_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hiscore_ram_arbiter_pkg.sv
// Shared types for the hiscore work-RAM arbiter: FSM states and mux select codes.
// No logic; imported by the interface users and the arbiter top.
package hiscore_ram_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        SETTLE,
        GRANT,
        RELEASE
    } arb_state_t;

    localparam logic ARB_SEL_CPU = 1'b0;
    localparam logic ARB_SEL_HS  = 1'b1;

    // SETTLE ends when the 8-bit counter reaches this value
    function automatic logic [7:0] settle_last(input int cycles);
        return 8'(cycles - 1);
    endfunction

endpackage

// File: rtl/hiscore_ram_arbiter_if.sv
// Bus bundle between CPU decode, hiscore engine and work-RAM port B.
// slave = arbiter side, master = surrounding system (CPU, engine, RAM).
interface hiscore_ram_arbiter_if #(
    parameter int ADDRESSWIDTH = 10
);
    logic                    hs_req;
    logic [ADDRESSWIDTH-1:0] hs_addr;
    logic [7:0]              hs_wdata;
    logic                    hs_we;
    logic                    hs_grant;
    logic [7:0]              hs_rdata;

    logic [ADDRESSWIDTH-1:0] cpu_addr;
    logic [7:0]              cpu_wdata;
    logic                    cpu_we;
    logic [7:0]              cpu_rdata;
    logic                    cpu_halt;
    logic                    cpu_halt_ack;

    logic [ADDRESSWIDTH-1:0] ram_addr;
    logic [7:0]              ram_wdata;
    logic                    ram_we;
    logic [7:0]              ram_q;

    modport slave (
        input  hs_req, hs_addr, hs_wdata, hs_we,
        output hs_grant, hs_rdata,
        input  cpu_addr, cpu_wdata, cpu_we, cpu_halt_ack,
        output cpu_rdata, cpu_halt,
        output ram_addr, ram_wdata, ram_we,
        input  ram_q
    );

    modport master (
        output hs_req, hs_addr, hs_wdata, hs_we,
        input  hs_grant, hs_rdata,
        output cpu_addr, cpu_wdata, cpu_we, cpu_halt_ack,
        input  cpu_rdata, cpu_halt,
        input  ram_addr, ram_wdata, ram_we,
        output ram_q
    );
endinterface

// File: rtl/hiscore_ram_arbiter.sv
// Purpose: hands the work-RAM port from the CPU to the hiscore engine after halt-ack + settle.
// Latency: req->halt 1 clk, ack->grant SETTLE_CYCLES+1 clk, req drop->grant 0 1 clk / halt 0 2 clk.
// Backpressure: CPU is stalled via cpu_halt; optional grant timeout under HISCORE_ARB_TIMEOUT_EN.
module hiscore_ram_arbiter
    import hiscore_ram_arbiter_pkg::*;
#(
    parameter int ADDRESSWIDTH   = 10,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    hiscore_ram_arbiter_if.slave io_bus,
    output logic                 o_blocked_wr,
    output logic                 o_timeout
);

    localparam logic [7:0] SETTLE_LAST = settle_last(SETTLE_CYCLES);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [7:0]              r_cnt;
    logic [7:0]              w_cnt_nxt;
    logic                    r_blocked_wr;
    logic                    w_grant;
    logic                    w_sel;
    logic                    w_req_ok;
    logic                    w_tmo_hit;
    logic [ADDRESSWIDTH-1:0] w_ram_addr;

`ifdef HISCORE_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] r_tcnt;
    logic          r_timeout;
    logic          r_need_low;

    assign w_tmo_hit = (r_state == GRANT) && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
    // after a forced release the engine must drop its request before it can win again
    assign w_req_ok  = io_bus.hs_req && !r_need_low;
    assign o_timeout = r_timeout;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tcnt     <= '0;
            r_timeout  <= 1'b0;
            r_need_low <= 1'b0;
        end else begin
            if (r_state != GRANT)
                r_tcnt <= '0;
            else if (r_tcnt != '1)
                r_tcnt <= r_tcnt + TW'(1);
            if (w_tmo_hit)
                r_timeout <= 1'b1;
            if (w_tmo_hit)
                r_need_low <= 1'b1;
            else if (!io_bus.hs_req)
                r_need_low <= 1'b0;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
    assign w_req_ok  = io_bus.hs_req;
    assign o_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_blocked_wr <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_grant && io_bus.cpu_we)
                r_blocked_wr <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_req_ok)
                    w_state_nxt = HALT;
            end
            HALT: begin
                if (!io_bus.hs_req) begin
                    w_state_nxt = RELEASE;
                end else if (io_bus.cpu_halt_ack) begin
                    w_state_nxt = SETTLE;
                    w_cnt_nxt   = '0;
                end
            end
            SETTLE: begin
                if (!io_bus.hs_req)
                    w_state_nxt = RELEASE;
                else if (r_cnt == SETTLE_LAST)
                    w_state_nxt = GRANT;
                else
                    w_cnt_nxt = r_cnt + 8'd1;
            end
            GRANT: begin
                if (!io_bus.hs_req || w_tmo_hit)
                    w_state_nxt = RELEASE;
            end
            RELEASE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // halt stays asserted through RELEASE so the CPU never restarts mid engine cycle
    assign w_grant         = (r_state == GRANT);
    assign io_bus.hs_grant = w_grant;
    assign io_bus.cpu_halt = (r_state != IDLE);
    assign w_sel           = w_grant ? ARB_SEL_HS : ARB_SEL_CPU;

    assign w_ram_addr       = (w_sel == ARB_SEL_HS) ? io_bus.hs_addr  : io_bus.cpu_addr;
    assign io_bus.ram_addr  = w_ram_addr;
    assign io_bus.ram_wdata = (w_sel == ARB_SEL_HS) ? io_bus.hs_wdata : io_bus.cpu_wdata;
    assign io_bus.ram_we    = (w_sel == ARB_SEL_HS) ? io_bus.hs_we    : io_bus.cpu_we;

    assign io_bus.hs_rdata  = io_bus.ram_q;
    assign io_bus.cpu_rdata = io_bus.ram_q;
    assign o_blocked_wr     = r_blocked_wr;

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Bench for hiscore_ram_arbiter: mux vector table, hand sequences for the handover corners,
// and a randomized run against a cycle-stamp reference model with a shadow RAM.
module tb_hiscore_ram_arbiter;

    localparam int AW     = 10;
    localparam int SETTLE = 4;
    localparam int TMO    = 16;

    logic clk = 1'b0;
    logic reset_n;
    logic blocked_wr;
    logic timeout;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hiscore_ram_arbiter_if #(.ADDRESSWIDTH(AW)) bus ();

    hiscore_ram_arbiter #(
        .ADDRESSWIDTH  (AW),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .io_bus      (bus),
        .o_blocked_wr(blocked_wr),
        .o_timeout   (timeout)
    );

    function automatic logic [7:0] pat(input logic [9:0] a);
        return a[7:0] ^ 8'hA5 ^ {6'b0, a[9:8]};
    endfunction

    // synchronous RAM, 1-cycle read latency, preloaded with a known pattern on the first edge
    logic [7:0] mem [0:1023];
    logic       mem_ok = 1'b0;
    always @(posedge clk) begin
        if (!mem_ok) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pat(10'(i));
            mem_ok <= 1'b1;
        end else begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_q <= mem[bus.ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.hs_req = 0; bus.hs_addr = '0; bus.hs_wdata = '0; bus.hs_we = 0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_we = 0; bus.cpu_halt_ack = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
    endtask

    task automatic go_grant();
        bus.hs_req = 1; bus.cpu_halt_ack = 1;
        for (int i = 0; i < 60 && !bus.hs_grant; i++) tick();
        chk("reach_grant", bus.hs_grant, 1);
    endtask

    task automatic go_idle();
        bus.hs_req = 0; bus.cpu_halt_ack = 0;
        for (int i = 0; i < 60 && bus.cpu_halt; i++) tick();
        chk("reach_idle", bus.cpu_halt, 0);
    endtask

    typedef struct {
        bit         g;
        logic [9:0] ca; logic [7:0] cd; logic cw;
        logic [9:0] ha; logic [7:0] hd; logic hw;
        logic [9:0] ea; logic [7:0] ed; logic ew;
    } vec_t;
    vec_t tbl [6];

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0]  h_exp;
        logic [7:0]  shadow [0:1023];
        logic [7:0]  exp_q;
        logic        halted, rel, m_blk, e_grant, e_we;
        logic [9:0]  e_addr;
        logic [7:0]  e_wd;
        int          ack_cyc, gcnt;

        tbl[0] = '{0, 10'h155, 8'h12, 0, 10'h2AA, 8'h34, 1, 10'h155, 8'h12, 0};
        tbl[1] = '{0, 10'h001, 8'h77, 1, 10'h3FF, 8'h88, 0, 10'h001, 8'h77, 1};
        tbl[2] = '{0, 10'h3FF, 8'hFF, 1, 10'h000, 8'h00, 1, 10'h3FF, 8'hFF, 1};
        tbl[3] = '{1, 10'h100, 8'h99, 0, 10'h0F0, 8'h5A, 1, 10'h0F0, 8'h5A, 1};
        tbl[4] = '{1, 10'h200, 8'h66, 1, 10'h00F, 8'hC3, 0, 10'h00F, 8'hC3, 0};
        tbl[5] = '{1, 10'h3FF, 8'hFF, 1, 10'h3FF, 8'h00, 1, 10'h3FF, 8'h00, 1};

        // reset values
        idle_inputs();
        reset_n = 1;
        #1 reset_n = 0;
        #2;
        chk("rst_grant", bus.hs_grant, 0);
        chk("rst_halt", bus.cpu_halt, 0);
        chk("rst_blocked", blocked_wr, 0);
        chk("rst_timeout", timeout, 0);
        do_reset();

        // mux vectors
        for (int i = 0; i < 6; i++) begin
            bus.cpu_we = 0; bus.hs_we = 0;
            if (tbl[i].g && !bus.hs_grant) go_grant();
            if (!tbl[i].g && bus.cpu_halt) go_idle();
            bus.cpu_addr = tbl[i].ca; bus.cpu_wdata = tbl[i].cd; bus.cpu_we = tbl[i].cw;
            bus.hs_addr  = tbl[i].ha; bus.hs_wdata  = tbl[i].hd; bus.hs_we  = tbl[i].hw;
            #1;
            chk($sformatf("mux_row%0d", i), {bus.ram_addr, bus.ram_wdata, bus.ram_we},
                {tbl[i].ea, tbl[i].ed, tbl[i].ew});
            tick();
        end

        // request, ack 3 clk later, engine write then readback
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            tick();
            bus.hs_req = 1; bus.cpu_halt_ack = (c >= 3);
            bus.hs_we = (c == 8); bus.hs_addr = 10'h0A3; bus.hs_wdata = 8'h5C;
            #1;
            if (c <= 9) begin
                chk($sformatf("t1_halt_c%0d", c), bus.cpu_halt, (c >= 1));
                chk($sformatf("t1_grant_c%0d", c), bus.hs_grant, (c >= 8));
            end else begin
                chk("t1_hs_rdata", bus.hs_rdata, 8'h5C);
            end
        end
        chk("t1_ram_0a3", mem[10'h0A3], 8'h5C);

        // CPU write during grant is dropped and flagged until reset
        tick();
        bus.cpu_we = 1; bus.cpu_addr = 10'h010; bus.cpu_wdata = 8'h11;
        tick();
        bus.cpu_we = 0;
        tick();
        chk("t2_ram_010", mem[10'h010], pat(10'h010));
        chk("t2_blocked", blocked_wr, 1);
        go_idle();
        tick();
        chk("t2_blocked_held", blocked_wr, 1);
        reset_n = 0;
        #1;
        chk("t2_blocked_rst", blocked_wr, 0);
        #1 reset_n = 1;

        // abort in SETTLE, request re-raised during RELEASE, CPU reads in the IDLE gap
        do_reset();
        h_exp = 9'b110111110;
        for (int c = 0; c <= 8; c++) begin
            tick();
            bus.hs_req = (c != 4); bus.cpu_halt_ack = (c >= 1);
            bus.cpu_addr = 10'h3F8;
            #1;
            chk($sformatf("t3_halt_c%0d", c), bus.cpu_halt, h_exp[c]);
            chk($sformatf("t3_grant_c%0d", c), bus.hs_grant, 0);
            if (c == 7) chk("t6_cpu_rdata", bus.cpu_rdata, pat(10'h3F8));
        end

        // async reset in the middle of a grant
        do_reset();
        go_grant();
        bus.hs_addr = 10'h123; bus.cpu_addr = 10'h321; bus.cpu_wdata = 8'h44;
        #1;
        chk("t4_pre_addr", bus.ram_addr, 10'h123);
        #1 reset_n = 0;
        #1;
        chk("t4_grant", bus.hs_grant, 0);
        chk("t4_halt", bus.cpu_halt, 0);
        chk("t4_ram", {bus.ram_addr, bus.ram_wdata}, {10'h321, 8'h44});
        tick();
        reset_n = 1;

        // grant length limit
        do_reset();
`ifdef HISCORE_ARB_TIMEOUT_EN
        bus.hs_req = 1; bus.cpu_halt_ack = 1;
        gcnt = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (bus.hs_grant) gcnt++;
        end
        chk("t5_grant_cycles", gcnt, TMO);
        chk("t5_timeout", timeout, 1);
        chk("t5_no_regrant", {bus.hs_grant, bus.cpu_halt}, 2'b00);
        bus.hs_req = 0;
        tick();
        go_grant();
        chk("t5_timeout_sticky", timeout, 1);
`else
        go_grant();
        repeat (40) tick();
        chk("t5_grant_held", bus.hs_grant, 1);
        chk("t5_timeout_off", timeout, 0);
`endif

`ifndef HISCORE_ARB_TIMEOUT_EN
        // randomized run against the reference model
        do_reset();
        for (int i = 0; i < 1024; i++) shadow[i] = mem[i];
        halted = 0; rel = 0; m_blk = 0; ack_cyc = -1; exp_q = '0;
        for (int c = 0; c < 2500; c++) begin
            tick();
            if ($urandom_range(0, 7) == 0) bus.hs_req = ~bus.hs_req;
            bus.cpu_halt_ack = ($urandom_range(0, 2) != 0);
            bus.cpu_addr = 10'($urandom); bus.cpu_wdata = 8'($urandom); bus.cpu_we = 1'($urandom);
            bus.hs_addr  = 10'($urandom); bus.hs_wdata  = 8'($urandom); bus.hs_we  = 1'($urandom);
            #1;
            e_grant = halted && (ack_cyc >= 0) && (c >= ack_cyc + SETTLE + 1);
            e_addr  = e_grant ? bus.hs_addr  : bus.cpu_addr;
            e_wd    = e_grant ? bus.hs_wdata : bus.cpu_wdata;
            e_we    = e_grant ? bus.hs_we    : bus.cpu_we;
            chk("rnd_ctl", {bus.cpu_halt, bus.hs_grant, bus.ram_addr, bus.ram_wdata, bus.ram_we},
                {(halted || rel), e_grant, e_addr, e_wd, e_we});
            chk("rnd_blocked", blocked_wr, m_blk);
            if (c > 0) chk("rnd_rdata", {bus.cpu_rdata, bus.hs_rdata}, {exp_q, exp_q});
            if (e_grant && bus.cpu_we) m_blk = 1;
            exp_q = shadow[e_addr];
            if (e_we) shadow[e_addr] = e_wd;
            if (rel) begin
                rel = 0;
            end else if (!halted) begin
                if (bus.hs_req) begin halted = 1; ack_cyc = -1; end
            end else if (!bus.hs_req) begin
                halted = 0; rel = 1; ack_cyc = -1;
            end else if (ack_cyc < 0 && bus.cpu_halt_ack) begin
                ack_cyc = c;
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
